// File: rtl/tawas_pkg.sv
// rtl/tawas_pkg.sv - shared types and helpers for the tawas thread scheduler
// Contents:
//   TAWAS_NTHR_MAX  largest supported hardware thread count
//   TAWAS_PC_W      default instruction word address width
//   pc_t            {half, addr} PC entry at the default width
//   tid_w(n)        width of a thread id for n threads (at least 1 bit)
package tawas_pkg;

  localparam int TAWAS_NTHR_MAX = 64;
  localparam int TAWAS_PC_W     = 24;

  typedef struct packed {
    logic                  half;
    logic [TAWAS_PC_W-1:0] addr;
  } pc_t;

  function automatic int tid_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tawas_rr_arb.sv
// rtl/tawas_rr_arb.sv - combinational round-robin grant over a request vector
// Ports:
//   req  in   N    request (ready) vector
//   ptr  in   IW   last granted index; search starts at ptr+1, cyclic
//   gnt  out  N    one-hot grant
//   idx  out  IW   index of the granted bit
//   any  out  1    at least one request present
module tawas_rr_arb
  import tawas_pkg::*;
#(
  parameter int N  = 32,
  parameter int IW = tid_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [N-1:0]   above;
  logic [2*N-1:0] dbl;
  logic           found;

  // The low half holds only requests strictly above ptr, the high half
  // holds all requests; the lowest set bit of the concatenation is the
  // first request after ptr, wrapping around through the high half.
  always_comb begin : pick
    int k;
    above = '0;
    for (int i = 0; i < N; i++) begin
      above[i] = (i > int'(ptr));
    end
    dbl   = {req, req & above};
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int j = 0; j < 2 * N; j++) begin
      if (!found && dbl[j]) begin
        found  = 1'b1;
        k      = (j >= N) ? (j - N) : j;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end
    end
    any = |req;
  end

endmodule

// File: rtl/tawas_thread_sched.sv
// rtl/tawas_thread_sched.sv - per-thread PC table and fetch thread scheduler
// Picks one runnable thread per cycle and presents {tid, pc, half} to fetch
// over a valid/ready handshake; tracks busy/halted per thread.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   thread_mask/thread_stall        per-thread enable / blocked
//   fetch_vld/rdy/tid/pc/half       fetch request handshake and payload
//   pc_upd_en/tid/pc                PC writeback, pc_upd_pc = {half, pc}
//   retire_en/tid, abort_en/tid     end of a pass; clears busy
//   halt_en/tid                     sets halted, clears busy
//   start_en/tid/pc                 clears halted, loads {0, start_pc}
//   thread_busy/thread_halted       per-thread state
module tawas_thread_sched
  import tawas_pkg::*;
#(
  parameter  int NTHR     = 32,
  parameter  int PC_W     = 24,
  parameter  int RR_EN    = 1,
  parameter  int RST_HALT = 0,
  localparam int TID_W    = tid_w(NTHR)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NTHR-1:0]  thread_mask,
  input  logic [NTHR-1:0]  thread_stall,
  output logic             fetch_vld,
  input  logic             fetch_rdy,
  output logic [TID_W-1:0] fetch_tid,
  output logic [PC_W-1:0]  fetch_pc,
  output logic             fetch_half,
  input  logic             pc_upd_en,
  input  logic [TID_W-1:0] pc_upd_tid,
  input  logic [PC_W:0]    pc_upd_pc,
  input  logic             retire_en,
  input  logic [TID_W-1:0] retire_tid,
  input  logic             abort_en,
  input  logic [TID_W-1:0] abort_tid,
  input  logic             halt_en,
  input  logic [TID_W-1:0] halt_tid,
  input  logic             start_en,
  input  logic [TID_W-1:0] start_tid,
  input  logic [PC_W-1:0]  start_pc,
  output logic [NTHR-1:0]  thread_busy,
  output logic [NTHR-1:0]  thread_halted
);

  typedef struct packed {
    logic            half;
    logic [PC_W-1:0] addr;
  } pc_ent_t;

  pc_ent_t          pc_q [NTHR];
  logic [TID_W-1:0] rr_ptr_q;

  logic [NTHR-1:0]  ready;
  logic [NTHR-1:0]  gnt;
  logic [TID_W-1:0] win;
  logic [TID_W-1:0] arb_ptr;
  logic             any_ready;
  logic             sel_fire;
  pc_ent_t          win_pc;

  logic [NTHR-1:0]  retire_oh;
  logic [NTHR-1:0]  abort_oh;
  logic [NTHR-1:0]  halt_oh;
  logic [NTHR-1:0]  start_oh;
  logic [NTHR-1:0]  upd_oh;
  logic [NTHR-1:0]  clear_oh;

  // Tids >= NTHR match no bit, so such events drop out here.
  always_comb begin
    retire_oh = '0;
    abort_oh  = '0;
    halt_oh   = '0;
    start_oh  = '0;
    upd_oh    = '0;
    for (int i = 0; i < NTHR; i++) begin
      retire_oh[i] = retire_en && (retire_tid == TID_W'(i));
      abort_oh[i]  = abort_en  && (abort_tid  == TID_W'(i));
      halt_oh[i]   = halt_en   && (halt_tid   == TID_W'(i));
      start_oh[i]  = start_en  && (start_tid  == TID_W'(i));
      upd_oh[i]    = pc_upd_en && (pc_upd_tid == TID_W'(i));
    end
    clear_oh = retire_oh | abort_oh | halt_oh;
  end

  assign ready    = ~thread_busy & thread_mask & ~thread_stall & ~thread_halted;
  // Fixed priority is round-robin with the pointer parked on the last tid.
  assign arb_ptr  = (RR_EN != 0) ? rr_ptr_q : TID_W'(NTHR - 1);
  assign sel_fire = (!fetch_vld || fetch_rdy) && any_ready;

  tawas_rr_arb #(
    .N  (NTHR),
    .IW (TID_W)
  ) u_arb (
    .req (ready),
    .ptr (arb_ptr),
    .gnt (gnt),
    .idx (win),
    .any (any_ready)
  );

  // Winner PC, forwarding a same-edge write with the same priority the
  // table applies (start over writeback) so fetch sees what gets stored.
  always_comb begin
    win_pc = '0;
    for (int i = 0; i < NTHR; i++) begin
      if (gnt[i]) win_pc = pc_q[i];
    end
    if (|(start_oh & gnt)) begin
      win_pc = '{half: 1'b0, addr: start_pc};
    end else if (|(upd_oh & gnt)) begin
      win_pc = pc_ent_t'(pc_upd_pc);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NTHR; i++) begin
        pc_q[i] <= '{half: 1'b0, addr: PC_W'(i)};
      end
      thread_busy   <= '0;
      thread_halted <= (RST_HALT != 0) ? ~NTHR'(1) : '0;
      rr_ptr_q      <= TID_W'(NTHR - 1);
      fetch_vld     <= 1'b0;
      fetch_tid     <= '0;
      fetch_pc      <= '0;
      fetch_half    <= 1'b0;
    end else begin
      for (int i = 0; i < NTHR; i++) begin
        if (start_oh[i]) begin
          pc_q[i] <= '{half: 1'b0, addr: start_pc};
        end else if (upd_oh[i]) begin
          pc_q[i] <= pc_ent_t'(pc_upd_pc);
        end
      end
      // Clears win over the select set for the same tid.
      thread_busy   <= (thread_busy | (sel_fire ? gnt : '0)) & ~clear_oh;
      thread_halted <= (thread_halted | halt_oh) & ~start_oh;
      if (sel_fire) begin
        fetch_vld  <= 1'b1;
        fetch_tid  <= win;
        fetch_pc   <= win_pc.addr;
        fetch_half <= win_pc.half;
        rr_ptr_q   <= win;
      end else if (fetch_rdy) begin
        fetch_vld  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tawas_thread_sched.sv
// tb/tb_tawas_thread_sched.sv - self-checking bench for tawas_thread_sched
module tb_tawas_thread_sched;

  localparam int NTHR  = 32;
  localparam int PC_W  = 24;
  localparam int TID_W = 5;
  localparam int BN    = 5;
  localparam int BW    = 3;
  localparam int BPC   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [NTHR-1:0]  thread_mask, thread_stall;
  logic             fetch_vld, fetch_rdy, fetch_half;
  logic [TID_W-1:0] fetch_tid;
  logic [PC_W-1:0]  fetch_pc;
  logic             pc_upd_en, retire_en, abort_en, halt_en, start_en;
  logic [TID_W-1:0] pc_upd_tid, retire_tid, abort_tid, halt_tid, start_tid;
  logic [PC_W:0]    pc_upd_pc;
  logic [PC_W-1:0]  start_pc;
  logic [NTHR-1:0]  thread_busy, thread_halted;

  logic [BN-1:0]  b_mask, b_stall, b_busy, b_halted;
  logic           b_vld, b_rdy, b_half;
  logic [BW-1:0]  b_tid, b_retire_tid, b_start_tid;
  logic [BPC-1:0] b_pc, b_start_pc;
  logic           b_retire_en, b_start_en;

  tawas_thread_sched #(.NTHR(NTHR), .PC_W(PC_W), .RR_EN(1), .RST_HALT(0)) dut (
    .clk(clk), .rst_n(rst_n), .thread_mask(thread_mask), .thread_stall(thread_stall),
    .fetch_vld(fetch_vld), .fetch_rdy(fetch_rdy), .fetch_tid(fetch_tid),
    .fetch_pc(fetch_pc), .fetch_half(fetch_half),
    .pc_upd_en(pc_upd_en), .pc_upd_tid(pc_upd_tid), .pc_upd_pc(pc_upd_pc),
    .retire_en(retire_en), .retire_tid(retire_tid), .abort_en(abort_en), .abort_tid(abort_tid),
    .halt_en(halt_en), .halt_tid(halt_tid), .start_en(start_en), .start_tid(start_tid),
    .start_pc(start_pc), .thread_busy(thread_busy), .thread_halted(thread_halted)
  );

  // Fixed priority, odd thread count, reset-halted variant.
  tawas_thread_sched #(.NTHR(BN), .PC_W(BPC), .RR_EN(0), .RST_HALT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .thread_mask(b_mask), .thread_stall(b_stall),
    .fetch_vld(b_vld), .fetch_rdy(b_rdy), .fetch_tid(b_tid),
    .fetch_pc(b_pc), .fetch_half(b_half),
    .pc_upd_en(1'b0), .pc_upd_tid(3'd0), .pc_upd_pc(17'd0),
    .retire_en(b_retire_en), .retire_tid(b_retire_tid), .abort_en(1'b0), .abort_tid(3'd0),
    .halt_en(1'b0), .halt_tid(3'd0), .start_en(b_start_en), .start_tid(b_start_tid),
    .start_pc(b_start_pc), .thread_busy(b_busy), .thread_halted(b_halted)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: per-thread arrays, pointer as an int, winner by scan.
  logic [PC_W:0]   m_pc [NTHR];
  logic [NTHR-1:0] m_busy, m_halted;
  int              m_rr, m_tid;
  logic            m_vld;
  logic [PC_W:0]   m_fpc;

  function automatic bit m_ready(input int t);
    return !m_busy[t] && thread_mask[t] && !thread_stall[t] && !m_halted[t];
  endfunction

  task automatic model_edge();
    int win;
    if (!rst_n) begin
      for (int t = 0; t < NTHR; t++) m_pc[t] = (PC_W+1)'(t);
      m_busy = '0; m_halted = '0; m_rr = NTHR - 1;
      m_vld = 1'b0; m_tid = 0; m_fpc = '0;
    end else begin
      win = -1;
      for (int k = 1; k <= NTHR; k++) begin
        if (win < 0 && m_ready((m_rr + k) % NTHR)) win = (m_rr + k) % NTHR;
      end
      if ((!m_vld || fetch_rdy) && win >= 0) begin
        m_vld = 1'b1;
        m_tid = win;
        if (start_en && int'(start_tid) == win) m_fpc = {1'b0, start_pc};
        else if (pc_upd_en && int'(pc_upd_tid) == win) m_fpc = pc_upd_pc;
        else m_fpc = m_pc[win];
        m_busy[win] = 1'b1;
        m_rr = win;
      end else if (fetch_rdy) begin
        m_vld = 1'b0;
      end
      if (retire_en) m_busy[retire_tid] = 1'b0;
      if (abort_en)  m_busy[abort_tid]  = 1'b0;
      if (halt_en)  begin m_busy[halt_tid] = 1'b0; m_halted[halt_tid] = 1'b1; end
      if (start_en)  m_halted[start_tid] = 1'b0;
      if (pc_upd_en) m_pc[pc_upd_tid] = pc_upd_pc;
      if (start_en)  m_pc[start_tid] = {1'b0, start_pc};
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check("vld",    64'(fetch_vld),            64'(m_vld));
    check("tid",    64'(fetch_tid),            64'(m_tid));
    check("pc",     64'({fetch_half, fetch_pc}), 64'(m_fpc));
    check("busy",   64'(thread_busy),          64'(m_busy));
    check("halted", 64'(thread_halted),        64'(m_halted));
  endtask

  task automatic idle();
    pc_upd_en = 0; retire_en = 0; abort_en = 0; halt_en = 0; start_en = 0;
    b_retire_en = 0; b_start_en = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic issue_all();
    thread_mask = '1; thread_stall = '0; fetch_rdy = 1'b1; idle();
    for (int k = 0; k < NTHR; k++) begin
      cycle();
      check("seq_tid", 64'(fetch_tid), 64'(k));
      check("seq_pc",  64'(fetch_pc),  64'(k));
    end
    cycle();
    check("seq_drop", 64'(fetch_vld), 64'(0));
    check("seq_busy", 64'(thread_busy), 64'hFFFF_FFFF);
  endtask

  initial begin : main
    int iss[3];
    int order[$];
    int n0, n1;
    bit found;

    rst_n = 1'b0; thread_mask = '0; thread_stall = '0; fetch_rdy = 1'b0;
    pc_upd_tid = '0; pc_upd_pc = '0; retire_tid = '0; abort_tid = '0;
    halt_tid = '0; start_tid = '0; start_pc = '0;
    b_mask = '0; b_stall = '0; b_rdy = 1'b0; b_retire_tid = '0; b_start_tid = '0;
    b_start_pc = '0;
    do_reset();
    check("rst_vld",  64'(fetch_vld), 64'(0));
    check("rst_busy", 64'(thread_busy), 64'(0));
    check("b_rst_halted", 64'(b_halted), 64'(5'b11110));
    check("b_rst_vld", 64'(b_vld), 64'(0));

    // Fixed priority: tid 6 is out of range; 0/1 retired at once starve 2.
    b_mask = '1; b_rdy = 1'b1; b_start_en = 1'b1; b_start_tid = 3'd6; b_start_pc = 16'h0060;
    cycle();
    check("b_oor_halted", 64'(b_halted), 64'(5'b11110));
    n0 = 0; n1 = 0;
    for (int i = 0; i < 24; i++) begin
      idle();
      b_retire_en  = b_vld && (b_tid != 3'd2);
      b_retire_tid = b_tid;
      if (i == 0 || i == 4) begin
        b_start_en  = 1'b1;
        b_start_tid = (i == 0) ? 3'd1 : 3'd2;
        b_start_pc  = 16'h0100;
      end
      cycle();
      check("b_starve", 64'(b_vld && b_tid == 3'd2), 64'(0));
      if (b_vld && b_tid == 3'd0) n0++;
      if (b_vld && b_tid == 3'd1) n1++;
    end
    check("b_halted_end", 64'(b_halted), 64'(5'b11000));
    check("b_busy2", 64'(b_busy[2]), 64'(0));
    check("b_both_run", 64'(n0 > 5 && n1 > 5), 64'(1));
    idle(); b_mask = '0; b_rdy = 1'b0;

    // Reset issue order: tids 0..31 back to back with pc = tid.
    issue_all();

    // Round-robin with a 3-cycle retire.
    do_reset();
    thread_mask = 32'h7; fetch_rdy = 1'b1;
    iss = '{-100, -100, -100};
    for (int i = 0; i < 30; i++) begin
      idle();
      for (int t = 0; t < 3; t++) begin
        if (iss[t] == cyc - 2) begin retire_en = 1'b1; retire_tid = TID_W'(t); end
      end
      cycle();
      if (fetch_vld && fetch_tid < 3) begin
        order.push_back(int'(fetch_tid));
        iss[fetch_tid] = cyc;
      end
    end
    for (int i = 0; i < 6; i++) begin
      check("rr_order", 64'((order.size() > i) ? order[i] : -1), 64'(i % 3));
    end

    // Backpressure held on tid 5.
    do_reset();
    thread_mask = '1; fetch_rdy = 1'b1;
    repeat (6) cycle();
    fetch_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("bp_tid",  64'(fetch_tid),   64'(5));
      check("bp_pc",   64'(fetch_pc),    64'(5));
      check("bp_busy", 64'(thread_busy), 64'h3F);
    end
    fetch_rdy = 1'b1;
    cycle();
    check("bp_next", 64'(fetch_tid), 64'(6));

    // Concurrent retire/abort/halt, then restart of the halted thread.
    repeat (4) cycle();
    fetch_rdy = 1'b0;
    retire_en = 1'b1; retire_tid = 5'd3;
    abort_en  = 1'b1; abort_tid  = 5'd7;
    halt_en   = 1'b1; halt_tid   = 5'd9;
    cycle();
    idle();
    check("clr_busy", 64'({thread_busy[9], thread_busy[7], thread_busy[3]}), 64'(0));
    check("clr_halt9", 64'(thread_halted[9]), 64'(1));
    thread_mask = (32'd1 << 9) | (32'd1 << 3); fetch_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      idle();
      retire_en = fetch_vld; retire_tid = fetch_tid;
      cycle();
      check("halt_no9", 64'(fetch_vld && fetch_tid == 5'd9), 64'(0));
    end
    idle();
    retire_en = fetch_vld; retire_tid = fetch_tid;
    start_en = 1'b1; start_tid = 5'd9; start_pc = 24'h001000;
    cycle();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      idle();
      retire_en = fetch_vld; retire_tid = fetch_tid;
      cycle();
      found = fetch_vld && fetch_tid == 5'd9;
    end
    check("start9_seen", 64'(found), 64'(1));
    check("start9_pc", 64'({fetch_half, fetch_pc}), 64'({1'b0, 24'h001000}));

    // Writeback forwarding into the winner, then start over writeback.
    do_reset();
    thread_mask = '1; fetch_rdy = 1'b1;
    repeat (4) cycle();
    pc_upd_en = 1'b1; pc_upd_tid = 5'd4; pc_upd_pc = {1'b1, 24'h000ABC};
    cycle();
    check("fwd_tid",  64'(fetch_tid),  64'(4));
    check("fwd_pc",   64'(fetch_pc),   64'h000ABC);
    check("fwd_half", 64'(fetch_half), 64'(1));
    idle();
    thread_mask = 32'd1 << 4;
    start_en = 1'b1; start_tid = 5'd4; start_pc = 24'h000777;
    pc_upd_en = 1'b1; pc_upd_tid = 5'd4; pc_upd_pc = {1'b1, 24'h000555};
    retire_en = 1'b1; retire_tid = 5'd4;
    cycle();
    idle();
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      cycle();
      found = fetch_vld && fetch_tid == 5'd4;
    end
    check("sp_seen", 64'(found), 64'(1));
    check("sp_pc", 64'({fetch_half, fetch_pc}), 64'({1'b0, 24'h000777}));

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      idle();
      thread_mask  = ($urandom_range(0, 7) == 0) ? NTHR'($urandom) : '1;
      thread_stall = NTHR'($urandom & $urandom & $urandom);
      fetch_rdy    = ($urandom_range(0, 3) != 0);
      retire_en  = $urandom_range(0, 1) == 1; retire_tid = TID_W'($urandom);
      abort_en   = $urandom_range(0, 4) == 0; abort_tid  = TID_W'($urandom);
      halt_en    = $urandom_range(0, 29) == 0; halt_tid  = TID_W'($urandom);
      start_en   = $urandom_range(0, 9) == 0; start_tid  = TID_W'($urandom);
      start_pc   = PC_W'($urandom);
      pc_upd_en  = $urandom_range(0, 2) == 0; pc_upd_tid = TID_W'($urandom);
      pc_upd_pc  = (PC_W+1)'($urandom);
      cycle();
    end

    // Reset while a request is stalled.
    idle(); thread_mask = '1; thread_stall = '0; fetch_rdy = 1'b1;
    found = fetch_vld;
    for (int i = 0; i < 64 && !found; i++) begin
      idle();
      retire_en = 1'b1; retire_tid = TID_W'(cyc);
      start_en  = 1'b1; start_tid  = TID_W'(cyc + 7); start_pc = PC_W'($urandom);
      cycle();
      found = fetch_vld;
    end
    check("rst6_have_req", 64'(found), 64'(1));
    idle(); fetch_rdy = 1'b0;
    cycle();
    check("rst6_held", 64'(fetch_vld), 64'(1));
    rst_n = 1'b0;
    cycle();
    check("rst6_vld",  64'(fetch_vld),   64'(0));
    check("rst6_busy", 64'(thread_busy), 64'(0));
    rst_n = 1'b1;
    issue_all();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
